// File: rtl/tdm_pkg.sv
// Shared definitions for the time-division domain multiplexer.
// Domain labels are plain binary domain indices 0..NDOM-1.
package tdm_pkg;

  localparam int NDOM_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int SLOT_DEF = 4;

  // Width of an index covering n values, never narrower than one bit.
  function automatic int dom_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Label of the domain that owns the slot after domain d.
  function automatic int dom_next(input int d, input int n);
    return (d >= n - 1) ? 0 : d + 1;
  endfunction

endpackage

// File: rtl/tdm_slot_sched.sv
// Fixed round-robin slot scheduler. It has no data inputs, so slot timing
// cannot depend on traffic from any domain.
module tdm_slot_sched
  import tdm_pkg::*;
#(
  parameter int NDOM  = NDOM_DEF,
  parameter int SLOT  = SLOT_DEF,
  localparam int DOM_W = dom_w(NDOM)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DOM_W-1:0] cur_dom,
  output logic             guard
);

  localparam int CNT_W = dom_w(SLOT);

  logic [CNT_W-1:0] slot_cnt;

  // Slot counter and owner; the owner advances when the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      cur_dom  <= '0;
    end else if (slot_cnt == CNT_W'(SLOT - 1)) begin
      slot_cnt <= '0;
      cur_dom  <= DOM_W'(dom_next(int'(cur_dom), NDOM));
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Last cycle of a slot is a guard cycle in which no input is taken.
  always_comb begin
    guard = (slot_cnt == CNT_W'(SLOT - 1));
  end

endmodule

// File: rtl/tdm_domain_mux.sv
// Time-division mux: each domain owns the output for a fixed slot. A word
// still unaccepted at the end of its slot is dropped instead of leaking into
// the next domain's slot.
module tdm_domain_mux
  import tdm_pkg::*;
#(
  parameter int NDOM  = NDOM_DEF,
  parameter int W     = W_DEF,
  parameter int SLOT  = SLOT_DEF,
  localparam int DOM_W = dom_w(NDOM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDOM*W-1:0] in_data,
  input  logic [NDOM-1:0]   in_valid,
  output logic [NDOM-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOM_W-1:0]  out_dom,
  output logic [DOM_W-1:0]  cur_dom,
  output logic              flush
);

  logic         guard;
  logic         can_load;
  logic         accept;
  logic [W-1:0] sel_data;

  tdm_slot_sched #(
    .NDOM (NDOM),
    .SLOT (SLOT)
  ) u_sched (
    .clk     (clk),
    .rst     (rst),
    .cur_dom (cur_dom),
    .guard   (guard)
  );

  // Ready only for the slot owner, outside the guard cycle, when the
  // output register is free or draining this cycle.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    accept   = 1'b0;
    can_load = !guard && (!out_valid || out_ready);
    for (int i = 0; i < NDOM; i++) begin
      if (DOM_W'(i) == cur_dom) begin
        in_ready[i] = can_load;
        sel_data    = in_data[i*W +: W];
        accept      = can_load && in_valid[i];
      end
    end
  end

  // Output register: load on accept, clear on drain, discard at slot end.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dom   <= '0;
      flush     <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_dom   <= cur_dom;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (out_valid && guard) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        flush     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_domain_mux.sv
// Directed bench for tdm_domain_mux with NDOM=4, W=8, SLOT=4.
module tb_tdm_domain_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_dom;
  logic [1:0]  cur_dom;
  logic        flush;

  int checks = 0;
  int errors = 0;

  tdm_domain_mux #(.NDOM(4), .W(8), .SLOT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dom   (out_dom),
    .cur_dom   (cur_dom),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    tick_n(2);

    // reset state: domain 0, slot 0
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dom", out_dom, 0);
    chk("rst_flush", flush, 0);
    chk("rst_cur_dom", cur_dom, 0);
    chk("rst_in_ready", in_ready, 4'b0001);
    rst = 1'b0;

    // idle schedule: each domain holds 4 cycles
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("idle_cur_dom_%0d", i), cur_dom, i / 4);
      chk($sformatf("idle_valid_%0d", i), out_valid, 0);
      chk($sformatf("idle_flush_%0d", i), flush, 0);
      tick();
    end

    // domain 2 valid during domains 0 and 1 is ignored
    in_valid = 4'b0100;
    in_data  = 32'h0077_0000;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("foreign_ready_%0d", i), in_ready,
          ((i % 4) == 3) ? 4'b0000 : ((i < 4) ? 4'b0001 : 4'b0010));
      tick();
      chk($sformatf("foreign_valid_%0d", i), out_valid, 0);
    end
    chk("d2_cur_dom", cur_dom, 2);
    chk("d2_ready", in_ready, 4'b0100);
    tick();
    in_valid = '0;
    chk("d2_valid", out_valid, 1);
    chk("d2_data", out_data, 8'h77);
    chk("d2_dom", out_dom, 2);
    chk("d2_ready_drain", in_ready, 4'b0100);
    tick();
    chk("d2_drain_valid", out_valid, 0);
    chk("d2_drain_data", out_data, 0);
    chk("d2_drain_dom_hold", out_dom, 2);
    tick_n(2);

    // domain 3 streams: three words per slot, guard cycle refuses
    chk("d3_cur_dom", cur_dom, 3);
    in_valid = 4'b1000;
    for (int s = 0; s < 3; s++) begin
      in_data = {8'hA0 + 8'(s), 24'h0};
      chk($sformatf("d3_ready_%0d", s), in_ready, 4'b1000);
      tick();
      chk($sformatf("d3_valid_%0d", s), out_valid, 1);
      chk($sformatf("d3_data_%0d", s), out_data, 8'hA0 + s);
      chk($sformatf("d3_dom_%0d", s), out_dom, 3);
    end
    in_data = 32'hA300_0000;
    chk("d3_guard_ready", in_ready, 4'b0000);
    tick();
    in_valid = '0;
    chk("d3_after_valid", out_valid, 0);
    chk("d3_after_data", out_data, 0);
    chk("d3_after_flush", flush, 0);
    chk("d3_after_dom", cur_dom, 0);

    // domain 0 word stuck under backpressure is flushed at slot end
    tick_n(2);
    in_valid  = 4'b0001;
    in_data   = 32'h0000_0011;
    out_ready = 1'b0;
    chk("fl_ready", in_ready, 4'b0001);
    tick();
    in_valid = '0;
    chk("fl_valid", out_valid, 1);
    chk("fl_data", out_data, 8'h11);
    chk("fl_dom", out_dom, 0);
    chk("fl_guard_ready", in_ready, 4'b0000);
    chk("fl_no_flush_yet", flush, 0);
    tick();
    chk("fl_cur_dom", cur_dom, 1);
    chk("fl_flush", flush, 1);
    chk("fl_valid_cleared", out_valid, 0);
    chk("fl_data_cleared", out_data, 0);
    chk("fl_dom_hold", out_dom, 0);
    tick();
    chk("fl_flush_pulse", flush, 0);

    // reset with a pending word at domain 2, slot 1
    tick_n(3);
    chk("rs_cur_dom", cur_dom, 2);
    in_valid = 4'b0100;
    in_data  = 32'h003C_0000;
    tick();
    in_valid = '0;
    chk("rs_valid", out_valid, 1);
    chk("rs_data", out_data, 8'h3C);
    chk("rs_backpressure_ready", in_ready, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_after_valid", out_valid, 0);
    chk("rs_after_data", out_data, 0);
    chk("rs_after_flush", flush, 0);
    chk("rs_after_cur_dom", cur_dom, 0);
    tick_n(3);
    chk("rs_slot_end_dom", cur_dom, 0);
    chk("rs_no_flush", flush, 0);
    tick();
    chk("rs_next_dom", cur_dom, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
